// File: rtl/snn_feeder.sv
// snn_feeder: collects one pattern of image bytes, holds kernel/weight
// coefficients, plays them to the SNN core as one contiguous burst, then
// waits for the core's result and forwards it downstream.
module snn_feeder #(
  parameter int N_PIX   = 72,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic       in_valid,
  output logic [7:0] img,
  output logic [7:0] ker,
  output logic [7:0] weight,
  input  logic       snn_out_valid,
  input  logic [9:0] snn_out_data,
  output logic       res_valid,
  output logic [9:0] res_data,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] pixBuf_q [N_PIX];
  logic [7:0] kReg_q [9];
  logic [7:0] wReg_q [4];
  logic [6:0] cnt_q;
  logic [9:0] waitCnt_q;

  logic       inValid_q;
  logic [7:0] img_q;
  logic [7:0] ker_q;
  logic [7:0] weight_q;
  logic       resValid_q;
  logic [9:0] resData_q;
  logic       timeoutErr_q;

  logic       pixFire_d;
  logic       lastPix_d;
  logic       cfgAccept_d;
  logic [3:0] wIdx_d;
  logic [6:0] cntNext_d;
  logic [7:0] kFirst_d;
  logic [7:0] wFirst_d;
  logic [7:0] kNext_d;
  logic [7:0] wNext_d;

  // Handshake, config-accept and next-burst-value decode. The first kernel and
  // weight values bypass the register file so that a coefficient write landing
  // on the final pixel handshake is already visible in the first burst beat.
  always_comb begin
    pixFire_d   = s_valid && (state_q == LOAD);
    lastPix_d   = pixFire_d && (cnt_q == 7'(N_PIX - 1));
    cfgAccept_d = cfg_we && (state_q != SEND) && (cfg_addr <= 4'd12);
    wIdx_d      = cfg_addr - 4'd9;
    cntNext_d   = cnt_q + 7'd1;
    kFirst_d    = (cfgAccept_d && (cfg_addr == 4'd0)) ? cfg_data : kReg_q[0];
    wFirst_d    = (cfgAccept_d && (cfg_addr == 4'd9)) ? cfg_data : wReg_q[0];
    kNext_d     = 8'd0;
    wNext_d     = 8'd0;
    if (cntNext_d < 7'd9) begin
      kNext_d = kReg_q[cntNext_d[3:0]];
    end
    if (cntNext_d < 7'd4) begin
      wNext_d = wReg_q[cntNext_d[1:0]];
    end
  end

  // Pixel buffer: written at the current count on every accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PIX; i++) begin
        pixBuf_q[i] <= 8'd0;
      end
    end else if (pixFire_d) begin
      pixBuf_q[cnt_q] <= s_data;
    end
  end

  // Coefficient register file; frozen while a burst is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        kReg_q[i] <= 8'd0;
      end
      for (int i = 0; i < 4; i++) begin
        wReg_q[i] <= 8'd0;
      end
    end else if (cfgAccept_d) begin
      if (cfg_addr < 4'd9) begin
        kReg_q[cfg_addr] <= cfg_data;
      end else begin
        wReg_q[wIdx_d[1:0]] <= cfg_data;
      end
    end
  end

  // Main controller: LOAD -> SEND -> WAIT with all core/downstream outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      cnt_q        <= 7'd0;
      waitCnt_q    <= 10'd0;
      inValid_q    <= 1'b0;
      img_q        <= 8'd0;
      ker_q        <= 8'd0;
      weight_q     <= 8'd0;
      resValid_q   <= 1'b0;
      resData_q    <= 10'd0;
      timeoutErr_q <= 1'b0;
    end else begin
      resValid_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (lastPix_d) begin
            cnt_q     <= 7'd0;
            state_q   <= SEND;
            inValid_q <= 1'b1;
            img_q     <= pixBuf_q[0];
            ker_q     <= kFirst_d;
            weight_q  <= wFirst_d;
          end else if (pixFire_d) begin
            cnt_q <= cntNext_d;
          end
        end
        SEND: begin
          if (cnt_q == 7'(N_PIX - 1)) begin
            cnt_q     <= 7'd0;
            state_q   <= WAIT;
            inValid_q <= 1'b0;
            img_q     <= 8'd0;
            ker_q     <= 8'd0;
            weight_q  <= 8'd0;
          end else begin
            cnt_q    <= cntNext_d;
            img_q    <= pixBuf_q[cntNext_d];
            ker_q    <= kNext_d;
            weight_q <= wNext_d;
          end
        end
        WAIT: begin
          if (snn_out_valid) begin
            resData_q  <= snn_out_data;
            resValid_q <= 1'b1;
            waitCnt_q  <= 10'd0;
            state_q    <= LOAD;
          end else if (waitCnt_q == 10'(TIMEOUT - 1)) begin
            timeoutErr_q <= 1'b1;
            waitCnt_q    <= 10'd0;
            state_q      <= LOAD;
          end else begin
            waitCnt_q <= waitCnt_q + 10'd1;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign in_valid    = inValid_q;
  assign img         = img_q;
  assign ker         = ker_q;
  assign weight      = weight_q;
  assign res_valid   = resValid_q;
  assign res_data    = resData_q;
  assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_snn_feeder.sv
// Testbench for snn_feeder: randomized frames, config traffic and core
// responses, checked every cycle against a queue-based behavioural model.
module tb_snn_feeder;

  localparam int N_PIX   = 72;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       in_valid;
  logic [7:0] img;
  logic [7:0] ker;
  logic [7:0] weight;
  logic       snn_out_valid;
  logic [9:0] snn_out_data;
  logic       res_valid;
  logic [9:0] res_data;
  logic       timeout_err;

  always #5 clk = ~clk;

  snn_feeder #(.N_PIX(N_PIX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .img(img), .ker(ker), .weight(weight),
    .snn_out_valid(snn_out_valid), .snn_out_data(snn_out_data),
    .res_valid(res_valid), .res_data(res_data), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state: phase 0 = collecting, 1 = bursting, 2 = awaiting result.
  int          mPhase;
  int          mWait;
  logic [7:0]  mK [9];
  logic [7:0]  mW [4];
  logic [7:0]  mPix [$];
  logic [23:0] mBurst [$];
  logic        expSReady, expInValid, expResValid, expTimeout;
  logic [7:0]  expImg, expKer, expWeight;
  logic [9:0]  expResData;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0;
    mWait  = 0;
    for (int i = 0; i < 9; i++) mK[i] = 8'd0;
    for (int i = 0; i < 4; i++) mW[i] = 8'd0;
    mPix.delete();
    mBurst.delete();
    expSReady   = 1'b1;
    expInValid  = 1'b0;
    expImg      = 8'd0;
    expKer      = 8'd0;
    expWeight   = 8'd0;
    expResValid = 1'b0;
    expResData  = 10'd0;
    expTimeout  = 1'b0;
  endtask

  task automatic showBeat(input logic [23:0] e);
    expInValid = 1'b1;
    expImg     = e[23:16];
    expKer     = e[15:8];
    expWeight  = e[7:0];
  endtask

  // Advance the model by one rising edge using the inputs the DUT just sampled.
  task automatic modelStep();
    logic [23:0] e;
    expResValid = 1'b0;
    if (mPhase != 1 && cfg_we && cfg_addr <= 4'd12) begin
      if (cfg_addr < 4'd9) mK[cfg_addr] = cfg_data;
      else mW[int'(cfg_addr) - 9] = cfg_data;
    end
    case (mPhase)
      0: begin
        if (s_valid) begin
          mPix.push_back(s_data);
          if (mPix.size() == N_PIX) begin
            for (int i = 0; i < N_PIX; i++) begin
              e = {mPix[i], (i < 9) ? mK[i % 9] : 8'd0, (i < 4) ? mW[i % 4] : 8'd0};
              mBurst.push_back(e);
            end
            mPix.delete();
            e = mBurst.pop_front();
            showBeat(e);
            mPhase = 1;
          end
        end
      end
      1: begin
        if (mBurst.size() == 0) begin
          expInValid = 1'b0;
          expImg     = 8'd0;
          expKer     = 8'd0;
          expWeight  = 8'd0;
          mPhase     = 2;
          mWait      = 0;
        end else begin
          e = mBurst.pop_front();
          showBeat(e);
        end
      end
      default: begin
        if (snn_out_valid) begin
          expResValid = 1'b1;
          expResData  = snn_out_data;
          mPhase      = 0;
        end else if (mWait == TIMEOUT - 1) begin
          expTimeout = 1'b1;
          mPhase     = 0;
        end else begin
          mWait++;
        end
      end
    endcase
    expSReady = (mPhase == 0);
  endtask

  task automatic checkOutput();
    checkVal("s_ready", 32'(s_ready), 32'(expSReady));
    checkVal("in_valid", 32'(in_valid), 32'(expInValid));
    checkVal("img", 32'(img), 32'(expImg));
    checkVal("ker", 32'(ker), 32'(expKer));
    checkVal("weight", 32'(weight), 32'(expWeight));
    checkVal("res_valid", 32'(res_valid), 32'(expResValid));
    checkVal("res_data", 32'(res_data), 32'(expResData));
    checkVal("timeout_err", 32'(timeout_err), 32'(expTimeout));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleInputs();
    s_valid       = 1'b0;
    s_data        = 8'd0;
    cfg_we        = 1'b0;
    cfg_addr      = 4'd0;
    cfg_data      = 8'd0;
    snn_out_valid = 1'b0;
    snn_out_data  = 10'd0;
  endtask

  task automatic writeCfg(input logic [3:0] a, input logic [7:0] d);
    idleInputs();
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    applyStimulus();
    idleInputs();
  endtask

  // Stream one full frame; ends at the negedge showing the first burst beat.
  task automatic loadFrame(input bit gaps, input bit randData, input bit randCfg,
                           input bit cfgOnLast, input logic [3:0] la, input logic [7:0] ld);
    int acc = 0;
    int cyc = 0;
    while (acc < N_PIX && cyc < 400) begin
      idleInputs();
      s_valid = gaps ? (cyc % 3 != 2) : 1'b1;
      s_data  = randData ? 8'($urandom) : 8'(acc);
      if (randCfg) begin
        cfg_we        = ($urandom_range(0, 3) == 0);
        cfg_addr      = 4'($urandom);
        cfg_data      = 8'($urandom);
        snn_out_valid = ($urandom_range(0, 4) == 0);
        snn_out_data  = 10'($urandom);
      end
      if (cfgOnLast && s_valid && acc == N_PIX - 1) begin
        cfg_we   = 1'b1;
        cfg_addr = la;
        cfg_data = ld;
      end
      applyStimulus();
      if (s_valid) acc++;
      cyc++;
    end
    idleInputs();
    if (acc < N_PIX) checkVal("frameLoadBound", 32'(acc), 32'(N_PIX));
  endtask

  // Advance n burst cycles; optionally hit addr 0 with 8'hFF at cycle wrAt.
  task automatic runBurst(input int n, input int wrAt, input bit randNoise);
    for (int i = 0; i < n; i++) begin
      idleInputs();
      if (i == wrAt) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 8'hFF;
      end
      if (randNoise) begin
        snn_out_valid = ($urandom_range(0, 5) == 0);
        snn_out_data  = 10'($urandom);
      end
      applyStimulus();
    end
    idleInputs();
  endtask

  // From WAIT: idle for delay cycles then present one result; ends where res_valid shows.
  task automatic respond(input int delay, input logic [9:0] data);
    for (int i = 0; i < delay; i++) begin
      idleInputs();
      if ($urandom_range(0, 2) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'($urandom_range(1, 15));
        cfg_data = 8'($urandom);
      end
      applyStimulus();
    end
    idleInputs();
    snn_out_valid = 1'b1;
    snn_out_data  = data;
    applyStimulus();
    idleInputs();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idleInputs();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput();
    checkVal("lit_reset_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;

    // Directed frame: k0..k8=1..9, w0..w3=10..13, pixels 0..71 without gaps.
    for (int a = 0; a < 13; a++) writeCfg(4'(a), 8'(a + 1));
    loadFrame(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < N_PIX; i++) begin
      if (i > 0) applyStimulus();
      checkVal("lit_in_valid", 32'(in_valid), 32'd1);
      checkVal("lit_img", 32'(img), 32'(i));
      checkVal("lit_ker", 32'(ker), (i < 9) ? 32'(i + 1) : 32'd0);
      checkVal("lit_weight", 32'(weight), (i < 4) ? 32'(10 + i) : 32'd0);
    end
    runBurst(1, -1, 1'b0);
    checkVal("lit_burst_end", 32'(in_valid), 32'd0);
    respond(3, 10'h2A5);
    checkVal("lit_res_valid", 32'(res_valid), 32'd1);
    checkVal("lit_res_data", 32'(res_data), 32'h2A5);
    checkVal("lit_res_s_ready", 32'(s_ready), 32'd1);
    applyStimulus();

    // Gapped, randomized frames with random config and stray core pulses.
    for (int f = 0; f < 3; f++) begin
      loadFrame(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      runBurst(N_PIX, -1, 1'b1);
      respond($urandom_range(0, TIMEOUT - 10), 10'($urandom));
      applyStimulus();
    end

    // Config frozen during SEND; same-cycle write on the last pixel is accepted.
    writeCfg(4'd0, 8'h21);
    loadFrame(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 8'h55);
    checkVal("lit_k0_first", 32'(ker), 32'h21);
    runBurst(1, -1, 1'b0);
    checkVal("lit_k1_same_cycle", 32'(ker), 32'h55);
    runBurst(N_PIX - 1, 2, 1'b0);
    respond(5, 10'($urandom));
    applyStimulus();
    loadFrame(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    checkVal("lit_k0_kept", 32'(ker), 32'h21);
    runBurst(N_PIX, -1, 1'b0);
    respond(2, 10'($urandom));
    applyStimulus();

    // Timeout: never answer, then a normal frame with the flag still set.
    loadFrame(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
    runBurst(N_PIX, -1, 1'b0);
    for (int i = 0; i < TIMEOUT + 5; i++) applyStimulus();
    checkVal("lit_timeout_err", 32'(timeout_err), 32'd1);
    checkVal("lit_timeout_load", 32'(s_ready), 32'd1);
    loadFrame(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    runBurst(N_PIX, -1, 1'b1);
    respond($urandom_range(0, 20), 10'($urandom));
    checkVal("lit_timeout_sticky", 32'(timeout_err), 32'd1);
    applyStimulus();

    // Asynchronous reset in the middle of a burst.
    loadFrame(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    runBurst(30, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkVal("lit_rst_in_valid", 32'(in_valid), 32'd0);
    checkVal("lit_rst_s_ready", 32'(s_ready), 32'd1);
    checkVal("lit_rst_timeout", 32'(timeout_err), 32'd0);
    modelReset();
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    loadFrame(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    runBurst(N_PIX, -1, 1'b0);
    respond(4, 10'($urandom));
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_feeder.md
# snn_feeder

Upstream stimulus stage for the SNN core. It captures one pattern's worth of image bytes over a valid/ready stream and holds kernel/weight coefficients in a small config register file. It then drives the core's serial `in_valid`/`img`/`ker`/`weight` input as one unbroken 72-cycle burst. It waits for the core's `out_valid`, forwards the 10-bit result downstream, and only then accepts the next frame.

## Interface
- `N_PIX`, default 72: image bytes per pattern (two 6x6 images), which is also the burst length.
- `TIMEOUT`, default 1000: maximum cycles spent in WAIT before giving up.
- `clk` in, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `s_valid` in, 1 bit: upstream pixel byte valid.
- `s_data` in, 8 bits: upstream pixel byte.
- `s_ready` out, 1 bit: feeder accepts a pixel this cycle.
- `cfg_we` in, 1 bit: coefficient write strobe.
- `cfg_addr` in, 4 bits: 0–8 select kernel taps k0..k8; 9–12 select weights w0..w3; 13–15 are ignored.
- `cfg_data` in, 8 bits: coefficient value.
- `in_valid` out, 1 bit: to the SNN core.
- `img` out, 8 bits: to the SNN core.
- `ker` out, 8 bits: to the SNN core.
- `weight` out, 8 bits: to the SNN core.
- `snn_out_valid` in, 1 bit: the SNN core's `out_valid`.
- `snn_out_data` in, 10 bits: the SNN core's `out_data`.
- `res_valid` out, 1 bit: result pulse to downstream.
- `res_data` out, 10 bits: result to downstream.
- `timeout_err` out, 1 bit: sticky flag, set when the WAIT timeout expires.

## Operation
- Storage:
  - 72x8 pixel buffer.
  - 9 kernel registers and 4 weight registers, all reset to 0.
  - 7-bit pixel/burst counter `cnt`.
  - 10-bit wait counter.
- State LOAD (reset state):
  - `s_ready`=1.
  - Each cycle with `s_valid & s_ready` writes `s_data` to `buf[cnt]` and increments `cnt`.
  - On the handshake where `cnt`=N_PIX-1: clear `cnt` and go to SEND.
- State SEND:
  - `s_ready`=0.
  - For `cnt`=0..N_PIX-1, drive registered outputs:
    - `in_valid`=1 and `img`=`buf[cnt]`.
    - `ker`=`k[cnt]` when `cnt`<9, else 0.
    - `weight`=`w[cnt]` when `cnt`<4, else 0.
  - After `cnt`=N_PIX-1: clear `cnt`, go to WAIT.
- State WAIT:
  - `s_ready`=0; the wait counter increments each cycle.
  - On `snn_out_valid`=1: capture `snn_out_data`, pulse `res_valid`, go to LOAD.
  - If the wait counter reaches TIMEOUT-1 without `snn_out_valid`: set `timeout_err`, go to LOAD.
  - The wait counter clears on leaving WAIT.
- Config writes:
  - Accepted in LOAD and WAIT.
  - Ignored (registers unchanged) in SEND, so coefficients stay stable for the whole burst.
  - Addresses 13–15 are ignored in every state.
- `snn_out_valid` outside WAIT is ignored: no `res_valid`, no state change.
- `timeout_err` clears only on reset.
- Outputs that are not active are driven to 0:
  - `img`/`ker`/`weight` are 0 whenever `in_valid`=0.
  - `res_data` holds its last captured value and may change only with `res_valid`.

## Timing
- Reset values: `s_ready`=1 (LOAD), `in_valid`=0, `img`/`ker`/`weight`=0, `res_valid`=0, `res_data`=0, `timeout_err`=0, `cnt`=0, all buffers and coefficients 0.
- Reset asserted mid-operation (any state): returns to LOAD immediately. A partially loaded frame and any in-flight burst are discarded; `in_valid` drops asynchronously.
- The cycle after the 72nd pixel handshake is the first SEND cycle; `in_valid`=1 with `img`=`buf[0]`, `ker`=k0, `weight`=w0.
- `in_valid` stays high for exactly N_PIX consecutive cycles with no gaps.
- `s_valid` may toggle freely in LOAD; gaps simply stall `cnt`.
- `res_valid` rises one cycle after `snn_out_valid` is sampled in WAIT, lasts 1 cycle, and carries `res_data`=the sampled `snn_out_data`.
- LOAD is re-entered (`s_ready`=1) in the same cycle `res_valid` is high.
- A `cfg_we` arriving in the same cycle as the LOAD→SEND transition is accepted, because the FSM is still in LOAD that cycle.

## Test plan
- Write k0..k8=1..9 and w0..w3=10..13, stream pixels 0..71 with no gaps → starting the cycle after the last pixel: 72 cycles of `in_valid`=1, `img`=0..71, `ker`=1..9 then 0, `weight`=10..13 then 0.
- Stream 72 pixels with `s_valid` low on every third cycle → the burst starts only after the 72nd accepted pixel and remains contiguous with correct order.
- In WAIT, pulse `snn_out_valid` with `snn_out_data`=10'h2A5 → `res_valid` pulses one cycle later with `res_data`=10'h2A5; `s_ready` returns to 1 in that same cycle.
- Issue `cfg_we` to address 0 with value 8'hFF during SEND → `ker` still shows the old k0 for the rest of the burst; a read-back burst on the next frame also shows the old k0.
- Never assert `snn_out_valid` → after TIMEOUT cycles in WAIT, `timeout_err`=1 and the FSM is back in LOAD; a second frame then completes normally with `timeout_err` still 1.
- Assert `rst_n` low at SEND `cnt`=30 → `in_valid`=0 immediately, `s_ready`=1 after release, and the next 72-pixel frame bursts from `img`=`buf[0]`.
